// File: rtl/alu_mul_seq.sv
// Sequential 16x16 unsigned shift-add multiplier that drives an external 16-bit ALU
// for every high-half addition; one iteration per clock, fixed 16-cycle run.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        zero,
  output logic        ovf16,
  output logic [15:0] alu_r,
  output logic [15:0] alu_s,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_y,
  input  logic        alu_c
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] OP_PASS_S = 4'b0000;
  localparam logic [3:0] OP_PASS_R = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0100;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] p_hi;
  logic [15:0] p_lo;
  logic [3:0]  cnt;
  logic [31:0] p_next;

  // ALU carry becomes the new top bit; the multiplier bit just consumed shifts out
  assign p_next = {alu_c, alu_y, p_lo[15:1]};

  always_comb begin
    alu_r  = '0;
    alu_s  = '0;
    alu_op = OP_PASS_S;
    if (state == RUN) begin
      alu_r  = p_hi;
      alu_s  = mcand;
      alu_op = p_lo[0] ? OP_ADD : OP_PASS_R;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      product <= '0;
      zero    <= 1'b1;
      ovf16   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            mcand <= a;
            p_hi  <= '0;
            p_lo  <= b;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          {p_hi, p_lo} <= p_next;
          cnt          <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= p_next;
            zero    <= (p_next == 32'd0);
            ovf16   <= |p_next[31:16];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq; a behavioural model of the external ALU closes the loop.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n, start, busy, done, zero, ovf16, alu_c;
  logic [15:0] a, b, alu_r, alu_s, alu_y;
  logic [31:0] product;
  logic [3:0]  alu_op;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_prod;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .zero(zero), .ovf16(ovf16),
    .alu_r(alu_r), .alu_s(alu_s), .alu_op(alu_op), .alu_y(alu_y), .alu_c(alu_c)
  );

  // external ALU: pass S, pass R, add R+S with carry out of bit 15
  always_comb begin
    {alu_c, alu_y} = 17'd0;
    case (alu_op)
      4'b0000: {alu_c, alu_y} = {1'b0, alu_s};
      4'b0001: {alu_c, alu_y} = {1'b0, alu_r};
      4'b0100: {alu_c, alu_y} = {1'b0, alu_r} + {1'b0, alu_s};
      default: {alu_c, alu_y} = 17'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one multiply; n counts edges from the accepting edge, done is seen after edge 16
  task automatic run_mul(input logic [15:0] ta, input logic [15:0] tb_, input logic [31:0] exp,
                         input logic [3:0] eop, input bit chkop, input bit inject);
    int n = 0;
    int nbusy = 0;
    a = ta; b = tb_; start = 1'b1;
    while (!done && n < 40) begin
      tick(); n++;
      if (n == 1) begin
        start = 1'b0;
        chk("alu_s_run", {16'd0, alu_s}, {16'd0, ta});
        chk("alu_r_run", {16'd0, alu_r}, 32'd0);
      end
      if (inject && n == 5) begin start = 1'b1; a = 16'h7777; b = 16'h0009; end
      if (inject && n == 6) start = 1'b0;
      if (busy) begin
        nbusy++;
        if (chkop) chk("alu_op_run", {28'd0, alu_op}, {28'd0, eop});
      end
      if (n == 8) chk("product_hold", product, prev_prod);
    end
    chk("latency", n, 17);
    chk("busy_cycles", nbusy, 16);
    chk("product", product, exp);
    chk("zero", {31'd0, zero}, {31'd0, exp == 32'd0});
    chk("ovf16", {31'd0, ovf16}, {31'd0, exp[31:16] != 16'd0});
    prev_prod = exp;
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_op", {28'd0, alu_op}, 32'd0);
    chk("idle_alu_s", {16'd0, alu_s}, 32'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; prev_prod = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_ovf16", {31'd0, ovf16}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    reset_n = 1'b1;
    tick();

    run_mul(16'h0003, 16'h0005, 32'h0000_000F, 4'h0, 1'b0, 1'b0);
    run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0100, 1'b1, 1'b0);
    run_mul(16'h1234, 16'h0000, 32'h0000_0000, 4'b0001, 1'b1, 1'b0);
    run_mul(16'h00FF, 16'h0101, 32'h0000_FFFF, 4'h0, 1'b0, 1'b1);
    run_mul(16'h8000, 16'h0002, 32'h0001_0000, 4'h0, 1'b0, 1'b0);

    // reset in the middle of a run aborts it with no done pulse
    a = 16'h0005; b = 16'h0007; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_product", product, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n++;
      tick();
    end
    chk("abort_no_done", n, 0);
    prev_prod = 32'd0;

    // reset wins over start on the same edge
    reset_n = 1'b0; start = 1'b1; a = 16'h0009; b = 16'h0009;
    tick();
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1; start = 1'b0;
    tick();

    // back-to-back: start held high; operand change during RUN must be ignored
    a = 16'h0003; b = 16'h0004; start = 1'b1;
    tick();
    a = 16'h0002; b = 16'h0008;
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    chk("b2b_lat1", n, 17);
    chk("b2b_product1", product, 32'h0000_000C);
    tick();
    chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_pulse", {31'd0, done}, 32'd0);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    chk("b2b_lat2", n, 17);
    chk("b2b_product2", product, 32'h0000_0010);
    chk("b2b_ovf16", {31'd0, ovf16}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16-bit operands and a 32-bit product.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-005 a  input  16  multiplicand, unsigned; captured when start is accepted.
REQ-006 b  input  16  multiplier, unsigned; captured when start is accepted.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  high for exactly one cycle, in DONE.
REQ-009 product  output  32  registered unsigned a*b; held until the next accepted start.
REQ-010 zero  output  1  product == 0; registered with product.
REQ-011 ovf16  output  1  product[31:16] != 0; registered with product.
REQ-012 alu_r  output  16  R operand to the external 16-bit ALU.
REQ-013 alu_s  output  16  S operand to the external ALU.
REQ-014 alu_op  output  4  ALU function code: 0000 pass S, 0001 pass R, 0100 add R+S.
REQ-015 alu_y  input  16  ALU result Y.
REQ-016 alu_c  input  1  ALU carry C; carry out of bit 15 for add, 0 for pass.

Function
REQ-017 The block SHALL act as the ALU initiator and compute a 16x16 unsigned shift-add multiply, using the external ALU for every high-half addition.
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE + start -> RUN.
- RUN with iteration counter == 15 -> DONE.
- DONE + start -> RUN; DONE without start -> IDLE.
REQ-019 On an accepted start, the block SHALL load mcand <= a, P_hi <= 0, P_lo <= b and cnt <= 0.
REQ-020 In RUN, alu_r SHALL equal P_hi and alu_s SHALL equal mcand, combinationally from registers.
REQ-021 In RUN, alu_op SHALL be 0100 when P_lo[0] = 1 and 0001 otherwise.
REQ-022 Each RUN cycle SHALL update {P_hi, P_lo} <= {alu_c, alu_y, P_lo[15:1]} and cnt <= cnt + 1; cnt is 4-bit and wraps only on exit.
REQ-023 On the edge leaving RUN, the block SHALL load product with the final {P_hi, P_lo} value and update zero and ovf16 from it.
REQ-024 Latency SHALL be fixed: start sampled at edge 0, 16 iterations on edges 1-16, done high in the cycle after edge 16, which is 17 cycles after start.
REQ-025 In IDLE and DONE, the block SHALL drive alu_op = 0000 and alu_r = alu_s = 0.
REQ-026 A start asserted while in RUN SHALL be ignored; operands and progress are unaffected and the request is not queued.
REQ-027 A start in the DONE cycle SHALL be accepted (back-to-back operation); done still pulses for exactly that one cycle.
REQ-028 product, zero and ovf16 SHALL change only on the RUN->DONE edge and on reset.
REQ-029 Arithmetic SHALL be modulo-free: the product is exactly 32 bits, and the maximum case FFFF*FFFF = FFFE0001 is represented with no overflow loss.

Reset
REQ-030 When reset_n = 0 at a rising edge, the block SHALL enter IDLE with cnt, mcand, P_hi, P_lo and product all 0.
REQ-031 The reset values of the flag outputs SHALL be busy = 0, done = 0, zero = 1 and ovf16 = 0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and product SHALL read 0.
REQ-033 Reset SHALL take priority over start on the same edge.

Verification
REQ-034 a=0003, b=0005, start for 1 cycle -> busy for 16 cycles, then done=1 for 1 cycle, product=0000000F, zero=0, ovf16=0.
REQ-035 a=FFFF, b=FFFF -> product=FFFE0001, ovf16=1, zero=0; alu_op=0100 on all 16 RUN cycles.
REQ-036 a=1234, b=0000 -> product=0, zero=1; alu_op=0001 on all 16 RUN cycles.
REQ-037 start pulsed at RUN cycle 5 with new operands -> ignored; the first result is unchanged and done fires 17 cycles after the original start.
REQ-038 reset_n=0 at RUN cycle 8 -> next cycle IDLE with busy=0, product=0, zero=1, and no done pulse.
REQ-039 start held high through DONE with a=0002, b=0008 -> the first done pulses, a second RUN begins immediately, and 17 cycles later product=00000010.
